bus_arbiter_decoder: RTL

- Bus front end: arbitrates two masters (M0 = CPU, M1 = DMA) onto one shared bus and decodes the granted address into the 5-bit one-hot slave select.
- Drives the 32-bit 6-to-1 read-data mux select directly upstream: 10000 = slave0 … 00001 = slave4, 00000 = none (mux returns 0).
- Provides the combinational write select and a one-cycle-delayed read select aligned with registered slave read data.

---
 rtl/bus_arbiter_decoder_pkg.sv | 23 ++
 rtl/bus_arbiter_decoder_addr_decoder.sv | 23 ++
 rtl/bus_arbiter_decoder.sv | 83 ++++++++
 3 files changed

// File: rtl/bus_arbiter_decoder_pkg.sv
// Shared constants for the bus arbiter/decoder: region codes, one-hot
// slave selects and arbiter state encoding.
package bus_arbiter_decoder_pkg;

    localparam logic [2:0] REG_S0 = 3'd0;
    localparam logic [2:0] REG_S1 = 3'd1;
    localparam logic [2:0] REG_S2 = 3'd2;
    localparam logic [2:0] REG_S3 = 3'd3;
    localparam logic [2:0] REG_S4 = 3'd4;

    localparam logic [4:0] SEL_S0   = 5'b10000;
    localparam logic [4:0] SEL_S1   = 5'b01000;
    localparam logic [4:0] SEL_S2   = 5'b00100;
    localparam logic [4:0] SEL_S3   = 5'b00010;
    localparam logic [4:0] SEL_S4   = 5'b00001;
    localparam logic [4:0] SEL_NONE = 5'b00000;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_decoder_addr_decoder.sv
// Region field to one-hot slave select; regions 5..7 are unmapped.
module addr_decoder
    import bus_arbiter_decoder_pkg::*;
(
    input  logic [2:0] region,
    output logic [4:0] sel,
    output logic       unmapped
);

    always_comb begin
        sel      = SEL_NONE;
        unmapped = 1'b0;
        case (region)
            REG_S0:  sel = SEL_S0;
            REG_S1:  sel = SEL_S1;
            REG_S2:  sel = SEL_S2;
            REG_S3:  sel = SEL_S3;
            REG_S4:  sel = SEL_S4;
            default: unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_decoder.sv
// Two-master bus front end: parking arbiter (M0 default, no preemption),
// address decode, and registered read select / unmapped-address pulse.
module bus_arbiter_decoder
    import bus_arbiter_decoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_SLAVE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_wr,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic                 m1_req,
    input  logic                 m1_wr,
    input  logic [ADDR_W-1:0]    m1_addr,
    output logic                 m0_grant,
    output logic                 m1_grant,
    output logic [ADDR_W-1:0]    s_addr,
    output logic                 s_wr,
    output logic [NUM_SLAVE-1:0] s_sel,
    output logic [NUM_SLAVE-1:0] rd_sel,
    output logic                 addr_err
);

    arb_state_t           state;
    logic                 act_req;
    logic                 act_wr;
    logic [NUM_SLAVE-1:0] dec_sel;
    logic                 unmapped;

    always_comb begin
        if (state == GNT_M1) begin
            s_addr  = m1_addr;
            act_req = m1_req;
            act_wr  = m1_wr;
        end else begin
            s_addr  = m0_addr;
            act_req = m0_req;
            act_wr  = m0_wr;
        end
        s_wr  = act_wr & act_req;
        s_sel = act_req ? dec_sel : SEL_NONE;
    end

    addr_decoder u_addr_decoder (
        .region   (s_addr[ADDR_W-1:ADDR_W-3]),
        .sel      (dec_sel),
        .unmapped (unmapped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GNT_M0;
            m0_grant <= 1'b1;
            m1_grant <= 1'b0;
            rd_sel   <= SEL_NONE;
            addr_err <= 1'b0;
        end else begin
            // Grants are registered alongside the state so they never glitch.
            case (state)
                GNT_M0: if (!m0_req && m1_req) begin
                    state    <= GNT_M1;
                    m0_grant <= 1'b0;
                    m1_grant <= 1'b1;
                end
                GNT_M1: if (!m1_req) begin
                    state    <= GNT_M0;
                    m0_grant <= 1'b1;
                    m1_grant <= 1'b0;
                end
                default: begin
                    state    <= GNT_M0;
                    m0_grant <= 1'b1;
                    m1_grant <= 1'b0;
                end
            endcase
            rd_sel   <= (act_req && !act_wr) ? s_sel : SEL_NONE;
            addr_err <= act_req & unmapped;
        end
    end

endmodule
